// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding four byte requesters into one UART transmit engine,
// with a start-timeout watchdog and a sticky error flag.
module uart_tx_arbiter #(
    parameter int unsigned START_TIMEOUT = 16
) (
    input  logic        i_Clock,
    input  logic        rstn,
    input  logic [3:0]  i_req_valid,
    input  logic [31:0] i_req_byte,
    output logic [3:0]  o_req_ready,
    output logic        o_tx_dv,
    output logic [7:0]  o_tx_byte,
    input  logic        i_tx_active_l,
    output logic [1:0]  o_grant,
    output logic        o_busy,
    output logic        o_err,
    input  logic        i_err_clr
);

    localparam int unsigned NREQ    = 4;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned GRANT_W = 2;
    localparam int unsigned CNT_W   = $clog2(START_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(START_TIMEOUT);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_LAUNCH     = 2'd1;
    localparam logic [1:0] S_WAIT_START = 2'd2;
    localparam logic [1:0] S_WAIT_DONE  = 2'd3;

    logic [1:0]         state_q,      state_d;
    logic [NREQ-1:0]    req_ready_q,  req_ready_d;
    logic               tx_dv_q,      tx_dv_d;
    logic [BYTE_W-1:0]  tx_byte_q,    tx_byte_d;
    logic [GRANT_W-1:0] grant_q,      grant_d;
    logic [GRANT_W-1:0] last_grant_q, last_grant_d;
    logic               busy_q,       busy_d;
    logic               err_q,        err_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;

    logic               pick_found;
    logic [GRANT_W-1:0] pick_idx;
    logic [GRANT_W-1:0] probe_idx;
    logic [BYTE_W-1:0]  pick_byte;

    // Round-robin search starting one past the previous owner, plus byte mux for the winner
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        probe_idx  = '0;
        pick_byte  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            probe_idx = last_grant_q + GRANT_W'(i);
            if (!pick_found && i_req_valid[probe_idx]) begin
                pick_found = 1'b1;
                pick_idx   = probe_idx;
            end
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (pick_idx == GRANT_W'(k)) begin
                pick_byte = i_req_byte[k*BYTE_W +: BYTE_W];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        req_ready_d  = '0;
        tx_dv_d      = 1'b0;
        tx_byte_d    = tx_byte_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        err_d        = err_q & ~i_err_clr;
        cnt_d        = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (i_tx_active_l && pick_found) begin
                    grant_d     = pick_idx;
                    tx_byte_d   = pick_byte;
                    tx_dv_d     = 1'b1;
                    req_ready_d = NREQ'(1) << pick_idx;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (!i_tx_active_l) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q >= CNT_LAST) begin
                    // Engine never started: flag it and give the slot away; set beats clear
                    err_d        = 1'b1;
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (i_tx_active_l) begin
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge i_Clock) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            req_ready_q  <= '0;
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= '0;
            grant_q      <= '0;
            last_grant_q <= GRANT_W'(NREQ - 1);
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            tx_dv_q      <= tx_dv_d;
            tx_byte_q    <= tx_byte_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_tx_dv     = tx_dv_q;
    assign o_tx_byte   = tx_byte_q;
    assign o_grant     = grant_q;
    assign o_busy      = busy_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// transactions scored against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [31:0] req_byte;
    logic [3:0]  req_ready;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active_l;
    logic [1:0]  grant;
    logic        busy;
    logic        err;
    logic        err_clr;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int   last_grant_m = 3;
    logic err_m        = 1'b0;

    uart_tx_arbiter #(.START_TIMEOUT(TO)) dut (
        .i_Clock       (clk),
        .rstn          (rstn),
        .i_req_valid   (req_valid),
        .i_req_byte    (req_byte),
        .o_req_ready   (req_ready),
        .o_tx_dv       (tx_dv),
        .o_tx_byte     (tx_byte),
        .i_tx_active_l (tx_active_l),
        .o_grant       (grant),
        .o_busy        (busy),
        .o_err         (err),
        .i_err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Winner = first valid requester scanning upward from last owner + 1, wrapping
    function automatic int rr_pick(input logic [3:0] mask);
        for (int i = 1; i <= 4; i++) begin
            int c;
            c = (last_grant_m + i) % 4;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    // One full request: arbitration, launch, then engine start/finish or a timeout
    task automatic run_txn(input logic [3:0] mask, input logic [31:0] bytes,
                           input bit timeout, input int delay, input bit clr_at_to,
                           output int k_out);
        int k;
        int n;
        logic [7:0] exp_byte;
        k        = rr_pick(mask);
        exp_byte = bytes[8*k +: 8];
        k_out    = k;
        req_valid = mask;
        req_byte  = bytes;
        n = 0;
        step();
        n = 1;
        while (tx_dv !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk("launch_latency", 32'(n), 32'd1);
        chk("ready_onehot", 32'(req_ready), 32'(1) << k);
        chk("grant_idx", 32'(grant), 32'(k));
        chk("tx_byte", 32'(tx_byte), 32'(exp_byte));
        chk("busy_launch", 32'(busy), 32'd1);
        req_valid = 4'b0000;
        step();
        n = 1;
        chk("dv_one_cycle", 32'(tx_dv), 32'd0);
        chk("ready_one_cycle", 32'(req_ready), 32'd0);
        if (timeout) begin
            while (busy !== 1'b0 && n < 40) begin
                err_clr = clr_at_to && (n == TO);
                step();
                n++;
            end
            err_clr = 1'b0;
            err_m   = 1'b1;
            chk("timeout_cycles", 32'(n), 32'(TO + 1));
            chk("err_after_timeout", 32'(err), 32'(err_m));
        end else begin
            while (n < delay) begin
                step();
                n++;
            end
            tx_active_l = 1'b0;
            repeat (10) step();
            chk("busy_while_active", 32'(busy), 32'd1);
            tx_active_l = 1'b1;
            step();
            chk("busy_after_done", 32'(busy), 32'd0);
            chk("err_hold", 32'(err), 32'(err_m));
        end
        chk("byte_stable", 32'(tx_byte), 32'(exp_byte));
        last_grant_m = k;
    endtask

    initial begin
        int k;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};

        rstn        = 1'b0;
        req_valid   = 4'b0000;
        req_byte    = 32'h0;
        tx_active_l = 1'b1;
        err_clr     = 1'b0;
        repeat (2) step();
        chk("rst_dv", 32'(tx_dv), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_byte", 32'(tx_byte), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rstn = 1'b1;
        step();

        // All four requesting: strict rotation starting at requester 0
        for (int i = 0; i < 5; i++) begin
            run_txn(4'b1111, 32'hA3A2A1A0, 1'b0, 2, 1'b0, k);
            chk("rr_order", 32'(k), 32'(exp_order[i]));
        end

        // Single requester with byte 0x55
        run_txn(4'b0001, 32'h00000055, 1'b0, 2, 1'b0, k);
        chk("single_grant", 32'(k), 32'd0);

        // Engine never starts: timeout, then rotation continues and clear works
        run_txn(4'b1111, 32'h13121110, 1'b1, 0, 1'b0, k);
        chk("timeout_owner", 32'(k), 32'd1);
        run_txn(4'b1111, 32'h23222120, 1'b0, 3, 1'b0, k);
        chk("after_timeout_owner", 32'(k), 32'd2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        err_m   = 1'b0;
        chk("err_cleared", 32'(err), 32'(err_m));

        // Timeout coincident with clear: set wins
        run_txn(4'b1111, 32'h33323130, 1'b1, 0, 1'b1, k);
        step();
        chk("set_beats_clr", 32'(err), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        err_m   = 1'b0;

        // Engine held busy externally: no grant until it reports idle
        tx_active_l = 1'b0;
        req_valid   = 4'b0100;
        req_byte    = 32'h00C40000;
        repeat (5) step();
        chk("blocked_ready", 32'(req_ready), 32'd0);
        chk("blocked_busy", 32'(busy), 32'd0);
        chk("blocked_dv", 32'(tx_dv), 32'd0);
        tx_active_l = 1'b1;
        run_txn(4'b0100, 32'h00C40000, 1'b0, 2, 1'b0, k);
        chk("unblocked_owner", 32'(k), 32'd2);

        // Randomized traffic against the model
        for (int i = 0; i < 20; i++) begin
            logic [3:0] mask;
            bit         to;
            mask = 4'($urandom_range(1, 15));
            to   = ($urandom_range(0, 4) == 0);
            run_txn(mask, $urandom, to, int'($urandom_range(2, 12)),
                    to && ($urandom_range(0, 1) == 1), k);
            if (err_m) begin
                err_clr = 1'b1;
                step();
                err_clr = 1'b0;
                err_m   = 1'b0;
                chk("rand_err_clr", 32'(err), 32'd0);
            end
        end

        // Reset in the middle of a transmission
        req_valid = 4'b0010;
        req_byte  = 32'h0000BB00;
        step();
        req_valid = 4'b0000;
        step();
        tx_active_l = 1'b0;
        repeat (3) step();
        rstn      = 1'b0;
        req_valid = 4'b1111;
        req_byte  = 32'hD3D2D1D0;
        step();
        chk("midrst_dv", 32'(tx_dv), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_byte", 32'(tx_byte), 32'd0);
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        tx_active_l = 1'b1;
        step();
        chk("in_rst_dv", 32'(tx_dv), 32'd0);
        last_grant_m = 3;
        err_m        = 1'b0;
        rstn         = 1'b1;
        run_txn(4'b1111, 32'hD3D2D1D0, 1'b0, 2, 1'b0, k);
        chk("post_rst_owner", 32'(k), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
